// File: rtl/mole_field.sv
// Nine-hole whack-a-mole field: LFSR-driven spawning, per-hole lifetime/cooldown timers,
// and keyboard hit resolution producing the hole map and event pulses.
module mole_field #(
    parameter int unsigned SPAWN_PERIOD = 50_000_000,
    parameter int unsigned MOLE_LIFE    = 75_000_000,
    parameter int unsigned COOLDOWN     = 10_000_000,
    parameter int unsigned MAX_ACTIVE   = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic [3:0] one_pulse_pos,
    output logic [8:0] map,
    output logic [3:0] active_cnt,
    output logic       whack,
    output logic       escape,
    output logic       miss_key
);

    localparam int unsigned TMAX = (MOLE_LIFE > COOLDOWN) ? MOLE_LIFE : COOLDOWN;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int unsigned SW   = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [TW-1:0] LIFE_LOAD  = TW'(MOLE_LIFE - 1);
    localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_PERIOD - 1);
    localparam logic [3:0]    MAX_CNT    = 4'(MAX_ACTIVE);

    typedef enum logic [1:0] {StEmpty, StUp, StCool} hole_state_e;

    hole_state_e   state_q [9];
    hole_state_e   state_d [9];
    logic [TW-1:0] timer_q [9];
    logic [TW-1:0] timer_d [9];
    logic [SW-1:0] spawn_cnt_q, spawn_cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [8:0]    map_q, map_d;
    logic [3:0]    active_cnt_q, active_cnt_d;
    logic          whack_q, whack_d;
    logic          escape_q, escape_d;
    logic          miss_key_q, miss_key_d;

    logic       tick;
    logic [3:0] spawn_idx;
    logic       key_valid;
    logic [8:0] key_hole;

    always_comb begin
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        spawn_idx = (lfsr_q[3:0] >= 4'd9) ? lfsr_q[3:0] - 4'd9 : lfsr_q[3:0];
        tick      = en && (spawn_cnt_q == SPAWN_LAST);
        key_valid = en && (one_pulse_pos >= 4'd1) && (one_pulse_pos <= 4'd9);
        key_hole  = key_valid ? (9'd1 << (one_pulse_pos - 4'd1)) : 9'd0;
    end

    always_comb begin
        spawn_cnt_d  = spawn_cnt_q;
        whack_d      = 1'b0;
        escape_d     = 1'b0;
        miss_key_d   = 1'b0;
        map_d        = '0;
        active_cnt_d = '0;
        for (int i = 0; i < 9; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
        end

        if (clear) begin
            spawn_cnt_d = '0;
            for (int i = 0; i < 9; i++) begin
                state_d[i] = StEmpty;
                timer_d[i] = '0;
            end
        end else if (en) begin
            spawn_cnt_d = tick ? '0 : spawn_cnt_q + SW'(1);
            // map_q mirrors state_q == StUp, so it doubles as the "hole is up" vector.
            whack_d     = |(key_hole & map_q);
            miss_key_d  = key_valid && !(|(key_hole & map_q));
            for (int i = 0; i < 9; i++) begin
                unique case (state_q[i])
                    StEmpty: begin
                        if (tick && (spawn_idx == 4'(i)) && (active_cnt_q < MAX_CNT)) begin
                            state_d[i] = StUp;
                            timer_d[i] = LIFE_LOAD;
                        end
                    end
                    StUp: begin
                        // A hit on the expiring cycle wins over the timeout.
                        if (key_hole[i] || (timer_q[i] == '0)) begin
                            state_d[i] = StCool;
                            timer_d[i] = COOL_LOAD;
                            if (!key_hole[i]) begin
                                escape_d = 1'b1;
                            end
                        end else begin
                            timer_d[i] = timer_q[i] - TW'(1);
                        end
                    end
                    StCool: begin
                        if (timer_q[i] == '0) begin
                            state_d[i] = StEmpty;
                        end else begin
                            timer_d[i] = timer_q[i] - TW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StEmpty;
                        timer_d[i] = '0;
                    end
                endcase
            end
        end

        for (int i = 0; i < 9; i++) begin
            map_d[i]     = (state_d[i] == StUp);
            active_cnt_d = active_cnt_d + {3'b000, map_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q       <= LFSR_SEED;
            spawn_cnt_q  <= '0;
            map_q        <= '0;
            active_cnt_q <= '0;
            whack_q      <= 1'b0;
            escape_q     <= 1'b0;
            miss_key_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                state_q[i] <= StEmpty;
                timer_q[i] <= '0;
            end
        end else begin
            lfsr_q       <= lfsr_d;
            spawn_cnt_q  <= spawn_cnt_d;
            map_q        <= map_d;
            active_cnt_q <= active_cnt_d;
            whack_q      <= whack_d;
            escape_q     <= escape_d;
            miss_key_q   <= miss_key_d;
            for (int i = 0; i < 9; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign map        = map_q;
    assign active_cnt = active_cnt_q;
    assign whack      = whack_q;
    assign escape     = escape_q;
    assign miss_key   = miss_key_q;

endmodule

// File: tb/tb_mole_field.sv
// Self-checking bench for mole_field: a timestamp-based reference model of the field checked
// against the DUT every cycle, plus directed scenario checks.
module tb_mole_field;

    localparam int SP   = 8;
    localparam int LIFE = 20;
    localparam int CD   = 4;
    localparam int MAXA = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] one_pulse_pos = 4'd0;
    logic [8:0] map;
    logic [3:0] active_cnt;
    logic       whack, escape, miss_key;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mole_field #(
        .SPAWN_PERIOD(SP),
        .MOLE_LIFE   (LIFE),
        .COOLDOWN    (CD),
        .MAX_ACTIVE  (MAXA),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clear        (clear),
        .one_pulse_pos(one_pulse_pos),
        .map          (map),
        .active_cnt   (active_cnt),
        .whack        (whack),
        .escape       (escape),
        .miss_key     (miss_key)
    );

    // Reference model: time is counted in enabled cycles; each mole records when it escapes
    // and each vacated hole records when it becomes free again.
    int          m_ecnt;
    bit          m_up   [9];
    int          m_tesc [9];
    int          m_tfree[9];
    logic [15:0] m_lfsr, m_lf;
    int          m_pre, m_n, m_idx, m_k;
    bit          m_tick;
    logic [8:0]  exp_map;
    logic [3:0]  exp_cnt;
    logic        exp_whack, exp_escape, exp_miss;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_ecnt = 0;
            for (int i = 0; i < 9; i++) begin
                m_up[i] = 0; m_tesc[i] = 0; m_tfree[i] = -1;
            end
            exp_whack = 0; exp_escape = 0; exp_miss = 0;
        end else begin
            m_lf = m_lfsr;
            m_lfsr = {m_lf[0] ^ m_lf[2] ^ m_lf[3] ^ m_lf[5], m_lf[15:1]};
            exp_whack = 0; exp_escape = 0; exp_miss = 0;
            if (clear) begin
                m_ecnt = 0;
                for (int i = 0; i < 9; i++) begin
                    m_up[i] = 0; m_tfree[i] = -1;
                end
            end else if (en) begin
                m_pre = 0;
                for (int i = 0; i < 9; i++) m_pre += int'(m_up[i]);
                m_tick = (m_ecnt % SP) == SP - 1;
                m_ecnt++;
                m_n = m_ecnt;
                if (one_pulse_pos >= 1 && one_pulse_pos <= 9) begin
                    m_k = int'(one_pulse_pos) - 1;
                    if (m_up[m_k]) begin
                        m_up[m_k] = 0; m_tfree[m_k] = m_n + CD; exp_whack = 1;
                    end else begin
                        exp_miss = 1;
                    end
                end
                for (int i = 0; i < 9; i++) begin
                    if (m_up[i] && m_tesc[i] == m_n) begin
                        m_up[i] = 0; m_tfree[i] = m_n + CD; exp_escape = 1;
                    end
                end
                if (m_tick) begin
                    m_idx = int'(m_lf[3:0]);
                    if (m_idx >= 9) m_idx -= 9;
                    if (!m_up[m_idx] && m_n > m_tfree[m_idx] && m_pre < MAXA) begin
                        m_up[m_idx] = 1; m_tesc[m_idx] = m_n + LIFE;
                    end
                end
            end
        end
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            exp_map[i] = m_up[i];
            exp_cnt += 4'(m_up[i]);
        end
    end

    logic [15:0] dut_vec, exp_vec;
    assign dut_vec = {map, active_cnt, whack, escape, miss_key};
    assign exp_vec = {exp_map, exp_cnt, exp_whack, exp_escape, exp_miss};

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        en = 1'b0; clear = 1'b0; one_pulse_pos = 4'd0;
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int first_bit(input logic [8:0] v);
        for (int i = 0; i < 9; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        en = 1'b0; one_pulse_pos = 4'd0;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== 16'd0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0000", dut_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) next_cycle();
        n_tests++;
        if (dut_vec !== 16'd0 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL reset_hold: got %h want 0000", dut_vec);
        end
    endtask

    task automatic test_first_spawn;
        int h;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL spawn_model c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            n_tests++;
            if (c < 8 && map !== 9'd0) begin
                n_fail++; $display("FAIL spawn_early c=%0d: map %b want 0", c, map);
            end else if (c == 8 && ($countones(map) != 1 || active_cnt !== 4'd1)) begin
                n_fail++; $display("FAIL spawn_first: map %b cnt %0d want one-hot,1", map, active_cnt);
            end
        end
        h = first_bit(exp_map);
        if (h < 0) h = 0;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL life_model c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            n_tests++;
            if (c < 20 && (map[h] !== 1'b1 || escape !== 1'b0)) begin
                n_fail++; $display("FAIL life_up c=%0d: map[h]=%b esc=%b want 1,0", c, map[h], escape);
            end else if (c == 20 && (map[h] !== 1'b0 || escape !== 1'b1)) begin
                n_fail++; $display("FAIL life_escape: map[h]=%b esc=%b want 0,1", map[h], escape);
            end
        end
        repeat (12) begin
            next_cycle();
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL cooldown_model: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic wait_rise(output int h);
        logic [8:0] prev;
        h = -1;
        prev = exp_map;
        for (int c = 0; c < 60 && h < 0; c++) begin
            next_cycle();
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL rise_model: got %h want %h", dut_vec, exp_vec);
            end
            h = first_bit(exp_map & ~prev);
            prev = exp_map;
        end
        if (h < 0) begin
            n_fail++; $display("FAIL rise_timeout: got none want a spawn");
        end
    endtask

    task automatic test_whack;
        int h;
        do_reset();
        en = 1'b1;
        wait_rise(h);
        if (h >= 0) begin
            one_pulse_pos = 4'(h + 1);
            next_cycle();
            one_pulse_pos = 4'd0;
            n_tests++;
            if (whack !== 1'b1 || map[h] !== 1'b0 || escape !== 1'b0 || miss_key !== 1'b0) begin
                n_fail++; $display("FAIL whack: w=%b map[h]=%b e=%b m=%b want 1,0,0,0",
                                   whack, map[h], escape, miss_key);
            end
            repeat (30) begin
                next_cycle();
                n_tests++;
                if (dut_vec !== exp_vec) begin
                    n_fail++; $display("FAIL whack_model: got %h want %h", dut_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_hit_on_timeout;
        int h;
        do_reset();
        en = 1'b1;
        wait_rise(h);
        if (h >= 0) begin
            repeat (19) next_cycle();
            one_pulse_pos = 4'(h + 1);
            next_cycle();
            one_pulse_pos = 4'd0;
            n_tests++;
            if (whack !== 1'b1 || escape !== 1'b0 || map[h] !== 1'b0) begin
                n_fail++; $display("FAIL hit_timeout: w=%b e=%b map[h]=%b want 1,0,0",
                                   whack, escape, map[h]);
            end
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL hit_timeout_model: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_miss;
        logic [3:0] keys [3];
        logic [2:0] want [3];
        keys[0] = 4'd3;  want[0] = 3'b001;
        keys[1] = 4'd0;  want[1] = 3'b000;
        keys[2] = 4'd12; want[2] = 3'b000;
        do_reset();
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            one_pulse_pos = keys[j];
            next_cycle();
            n_tests++;
            if ({whack, escape, miss_key} !== want[j] || map !== 9'd0) begin
                n_fail++; $display("FAIL miss key=%0d: wem=%b map=%b want %b,0",
                                   keys[j], {whack, escape, miss_key}, map, want[j]);
            end
        end
        one_pulse_pos = 4'd0;
        next_cycle();
        n_tests++;
        if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL miss_model: got %h want %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            one_pulse_pos = ($urandom % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            en    = ($urandom % 16) != 0;
            clear = ($urandom % 80) == 0;
            next_cycle();
            n_tests++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL random_model c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            n_tests++;
            if (active_cnt > 4'(MAXA) || $countones(map) != int'(active_cnt)) begin
                n_fail++; $display("FAIL random_cnt c=%0d: cnt %0d map %b want <=3,popcount",
                                   c, active_cnt, map);
            end
        end
        one_pulse_pos = 4'd0; clear = 1'b0; en = 1'b1;
    endtask

    task automatic test_freeze_clear_rst;
        logic [8:0] frozen;
        bit got;
        do_reset();
        en = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            next_cycle();
            got = (exp_cnt == 4'd2);
        end
        if (!got) begin
            n_fail++; $display("FAIL freeze_timeout: got none want 2 moles");
        end
        frozen = map;
        en = 1'b0;
        one_pulse_pos = 4'd5;
        repeat (50) begin
            next_cycle();
            n_tests++;
            if (map !== frozen || {whack, escape, miss_key} !== 3'b000 || dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL freeze: map %b pulses %b want %b,000",
                                   map, {whack, escape, miss_key}, frozen);
            end
        end
        one_pulse_pos = 4'd0;
        en = 1'b1; clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        n_tests++;
        if (map !== 9'd0 || active_cnt !== 4'd0 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL clear: map %b cnt %0d want 0,0", map, active_cnt);
        end
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            next_cycle();
            got = (exp_map != 9'd0);
        end
        n_tests++;
        if (!got || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL respawn_after_clear: got %h want %h", dut_vec, exp_vec);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid: got %h want 0000", dut_vec);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_whack();
        test_hit_on_timeout();
        test_miss();
        test_random();
        test_freeze_clear_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
